// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path.
// Provides the FIR sample width, default parameter values for the decimating
// output buffer, and sat_round(), which rounds half-up, shifts and clamps.
package fir_pkg;

    localparam int SAMPLE_W = 16;

    localparam int DEF_M     = 4;
    localparam int DEF_SHIFT = 4;
    localparam int DEF_OUT_W = 12;
    localparam int DEF_DEPTH = 8;

    localparam logic signed [SAMPLE_W:0] WIDE_ONE = {{SAMPLE_W{1'b0}}, 1'b1};

    // One guard bit above SAMPLE_W so the rounding bias cannot wrap.
    // The result is clamped to out_w bits. It is returned sign-extended to
    // SAMPLE_W, so the caller keeps only the low out_w bits.
    function automatic logic signed [SAMPLE_W-1:0] sat_round(
        input logic signed [SAMPLE_W-1:0] y,
        input int                         shift,
        input int                         out_w
    );
        logic signed [SAMPLE_W:0] bias;
        logic signed [SAMPLE_W:0] t;
        logic signed [SAMPLE_W:0] s;
        logic signed [SAMPLE_W:0] hi;
        logic signed [SAMPLE_W:0] lo;
        bias = '0;
        if (shift > 0) bias = WIDE_ONE <<< (shift - 1);
        t  = {y[SAMPLE_W-1], y} + bias;
        s  = t >>> shift;
        hi = (WIDE_ONE <<< (out_w - 1)) - WIDE_ONE;
        lo = -(WIDE_ONE <<< (out_w - 1));
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Output stream of the decimating buffer (valid/ready, show-ahead data).
//   out_data  : signed head-of-FIFO sample (W bits)
//   out_valid : FIFO holds at least one sample
//   out_ready : consumer takes out_data this cycle
// The master modport is the buffer. The slave modport is the framer or DMA.
interface fir_decim_buffer_if
    import fir_pkg::*;
#(
    parameter int W = DEF_OUT_W
);
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_decim_buffer_sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, rst_p : clock and asynchronous active-high reset
//   push/wdata : write request and data. A push when full is ignored unless
//                a pop happens on the same edge.
//   pop        : read request. A pop when empty is ignored.
//   rdata      : registered head entry. It holds its value while empty.
//   full/empty : status flags
//   level      : occupancy, 0..DEPTH
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_p,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [WIDTH-1:0] head_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = count;
    assign rdata   = head_q;

    // NOTE: every variable written in always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)      count_nxt = count + (AW+1)'(1);
        else if (!do_push && do_pop) count_nxt = count - (AW+1)'(1);
    end

    // NOTE: the storage array is not reset. Only the pointers and count are
    // reset, and they alone decide which entries are valid. Keeping reset
    // off the array lets it map onto plain RAM or flops without reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            count <= count_nxt;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            // The head register follows the entry behind the one being popped.
            // That entry comes from memory when it already exists. It comes
            // straight from wdata when the FIFO is about to become empty, or
            // when the FIFO is already empty.
            if (do_pop) begin
                if (count > (AW+1)'(1)) head_q <= mem[rd_ptr + AW'(1)];
                else if (do_push)       head_q <= wdata;
            end else if (do_push && empty) begin
                head_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/fir_decim_buffer.sv
// Decimating output buffer behind the 21-tap FIR stage.
// It keeps 1 of every M valid samples, rounds half-up, shifts right by SHIFT,
// saturates to OUT_W bits, and queues the results in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_p : clock and asynchronous active-high reset
//   y_in       : signed FIR output sample
//   y_valid    : y_in valid. The FIR stage cannot be back-pressured.
//   out_if     : valid/ready stream of OUT_W-bit results (master side)
//   level      : FIFO occupancy
//   ovf        : sticky, set when a kept sample is lost to a full FIFO
//   clr_ovf    : synchronous clear of ovf. A new overflow on the same edge wins.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_p,
    input  logic signed [SAMPLE_W-1:0]  y_in,
    input  logic                        y_valid,
    fir_decim_buffer_if.master          out_if,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        ovf,
    input  logic                        clr_ovf
);
    localparam int PH_W = (M > 1) ? $clog2(M) : 1;

    logic [PH_W-1:0]            phase;
    logic                       keep;
    logic signed [SAMPLE_W-1:0] scaled_full;
    logic                       scale_valid;
    logic signed [OUT_W-1:0]    scale_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       drop;

    // Phase 0 is the kept slot, so the first valid sample after reset is kept.
    assign keep        = y_valid && (phase == '0);
    assign scaled_full = sat_round(y_in, SHIFT, OUT_W);

    // sat_round already clamped to OUT_W, so the upper bits only repeat the sign.
    if (OUT_W < SAMPLE_W) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^scaled_full[SAMPLE_W-1:OUT_W];
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            phase <= '0;
        end else if (y_valid) begin
            phase <= (phase == PH_W'(M - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            scale_valid <= 1'b0;
            scale_data  <= '0;
        end else begin
            scale_valid <= keep;
            if (keep) scale_data <= scaled_full[OUT_W-1:0];
        end
    end

    assign pop  = ~fifo_empty & out_if.out_ready;
    // When the FIFO is full, a push still fits if the head leaves on the same edge.
    assign drop = scale_valid & fifo_full & ~pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_p (rst_p),
        .push  (scale_valid),
        .pop   (pop),
        .wdata (scale_data),
        .rdata (out_if.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_if.out_valid = ~fifo_empty;

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p)        ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer, with two instances (M=1 and M=4).
// Both use SHIFT=4, OUT_W=12 and DEPTH=8.
module tb_fir_decim_buffer;
    logic clk = 1'b0;
    logic rst_p;
    always #5 clk = ~clk;

    logic signed [15:0] y1, y4;
    logic               v1, v4, c1, c4;
    logic [3:0]         level1, level4;
    logic               ovf1, ovf4;

    fir_decim_buffer_if #(.W(12)) bus1 ();
    fir_decim_buffer_if #(.W(12)) bus4 ();

    fir_decim_buffer #(.M(1), .SHIFT(4), .OUT_W(12), .DEPTH(8)) u_m1 (
        .clk(clk), .rst_p(rst_p), .y_in(y1), .y_valid(v1), .out_if(bus1),
        .level(level1), .ovf(ovf1), .clr_ovf(c1)
    );
    fir_decim_buffer #(.M(4), .SHIFT(4), .OUT_W(12), .DEPTH(8)) u_m4 (
        .clk(clk), .rst_p(rst_p), .y_in(y4), .y_valid(v4), .out_if(bus4),
        .level(level4), .ovf(ovf4), .clr_ovf(c4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic signed [15:0] t1_y [4] = '{16'sh0018, 16'shFFE8, 16'sh7FFF, 16'sh8000};
    int                 t1_e [4] = '{2, -1, 2047, -2048};

    initial begin
        int q[$];
        int exp_v;
        int held;
        bit stalled;
        int sent;

        rst_p = 1'b1;
        y1 = '0; v1 = 0; c1 = 0; y4 = '0; v4 = 0; c4 = 0;
        bus1.out_ready = 1'b0;
        bus4.out_ready = 1'b0;
        #3;
        check("rst_valid1", int'(bus1.out_valid), 0);
        check("rst_valid4", int'(bus4.out_valid), 0);
        check("rst_data1",  int'(bus1.out_data), 0);
        check("rst_level1", int'(level1), 0);
        check("rst_level4", int'(level4), 0);
        check("rst_ovf1",   int'(ovf1), 0);
        @(posedge clk);
        #1 rst_p = 1'b0;

        // Scaling, rounding, saturation (M=1, consumer always ready).
        bus1.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            v1 = (c < 4);
            if (c < 4) y1 = t1_y[c];
            tick();
            if (c >= 1) begin
                check("scale_valid", int'(bus1.out_valid), 1);
                check("scale_data",  int'(bus1.out_data), t1_e[c-1]);
            end
        end
        v1 = 0;
        tick();
        check("scale_empty", int'(bus1.out_valid), 0);

        // Decimation and latency (M=4). Input i = 16*i maps to output i.
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            v4 = (i < 16);
            y4 = 16'(16 * i);
            tick();
            if (i >= 1) begin
                exp_v = ((i - 1) < 16 && ((i - 1) % 4) == 0) ? 1 : 0;
                check("dec_valid", int'(bus4.out_valid), exp_v);
                if (exp_v == 1) check("dec_data", int'(bus4.out_data), i - 1);
            end
        end
        v4 = 0;

        // Overflow (M=1, consumer stalled). Sample v is y = 16*v.
        bus1.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            v1 = 1; y1 = 16'(16 * k); tick();
        end
        v1 = 0; tick(); tick();
        check("ovf_level8",  int'(level1), 8);
        check("ovf_before",  int'(ovf1), 0);
        v1 = 1; y1 = 16'(16 * 9); tick();
        v1 = 0; tick(); tick();
        check("ovf_level9",  int'(level1), 8);
        check("ovf_set",     int'(ovf1), 1);
        // A drop and a clear on the same edge leave ovf set.
        v1 = 1; y1 = 16'(16 * 10); tick();
        v1 = 0; c1 = 1; tick();
        c1 = 0;
        check("ovf_set_wins", int'(ovf1), 1);
        check("ovf_level10",  int'(level1), 8);
        bus1.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("drain_valid", int'(bus1.out_valid), 1);
            check("drain_data",  int'(bus1.out_data), k);
            tick();
        end
        check("drain_empty", int'(bus1.out_valid), 0);
        check("drain_level", int'(level1), 0);
        c1 = 1; tick(); c1 = 0;
        check("ovf_clear", int'(ovf1), 0);

        // Full FIFO with a push and a pop on every edge for 20 cycles.
        bus1.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            v1 = 1; y1 = 16'(16 * k); tick();
        end
        v1 = 0; tick(); tick();
        check("full_pre_level", int'(level1), 8);
        for (int j = 0; j <= 20; j++) begin
            v1 = (j < 20);
            y1 = 16'(16 * (9 + j));
            bus1.out_ready = (j >= 1);
            if (j >= 1) begin
                check("full_valid", int'(bus1.out_valid), 1);
                check("full_data",  int'(bus1.out_data), j);
            end
            tick();
            if (j >= 1) begin
                check("full_level", int'(level1), 8);
                check("full_ovf",   int'(ovf1), 0);
            end
        end
        v1 = 0;
        for (int k = 21; k <= 28; k++) begin
            check("full_drain", int'(bus1.out_data), k);
            tick();
        end
        check("full_empty", int'(bus1.out_valid), 0);

        // Backpressure: out_ready toggles every cycle, input every other cycle.
        sent = 0;
        stalled = 0;
        held = 0;
        for (int c = 0; c < 120; c++) begin
            bus1.out_ready = c[0];
            v1 = (c % 2 == 0) && (sent < 50);
            if (v1) begin
                sent++;
                y1 = 16'(16 * (100 + sent));
                q.push_back(100 + sent);
            end
            if (stalled) check("bp_hold", int'(bus1.out_data), held);
            if (bus1.out_valid && bus1.out_ready) begin
                if (q.size() > 0) check("bp_data", int'(bus1.out_data), q.pop_front());
                else              check("bp_extra", int'(bus1.out_data), -1);
            end
            stalled = bus1.out_valid && !bus1.out_ready;
            held = int'(bus1.out_data);
            tick();
        end
        v1 = 0;
        check("bp_all_seen", q.size(), 0);
        check("bp_ovf",      int'(ovf1), 0);

        // Asynchronous reset mid-operation: level=5, phase=2 on the M=4 instance.
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            v4 = 1; y4 = 16'(16 * i); tick();
        end
        v4 = 0; tick(); tick();
        check("mid_level5", int'(level4), 5);
        #2 rst_p = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus4.out_valid), 0);
        check("mid_rst_level", int'(level4), 0);
        check("mid_rst_ovf",   int'(ovf4), 0);
        @(posedge clk);
        #1 rst_p = 1'b0;
        v4 = 1; y4 = 16'(16 * 7);
        tick();
        v4 = 0;
        check("post_rst_lat1", int'(bus4.out_valid), 0);
        tick();
        check("post_rst_valid", int'(bus4.out_valid), 1);
        check("post_rst_data",  int'(bus4.out_data), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
